// File: rtl/pipe_mem_wb.sv
// MEM/WB pipeline register with write-back select, address-error exception
// capture (AdEL/AdES) and a retired-instruction counter.
module pipe_mem_wb #(
    parameter int WIDTH    = 32,
    parameter int RN_W     = 5,
    parameter int EXC_ADEL = 4,
    parameter int EXC_ADES = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             stall,
    input  logic             flush,
    input  logic             m_valid,
    input  logic [WIDTH-1:0] m_pc,
    input  logic [WIDTH-1:0] m_alu,
    input  logic [WIDTH-1:0] m_ramout,
    input  logic [RN_W-1:0]  m_rn,
    input  logic             m_wreg,
    input  logic             m_m2reg,
    input  logic             m_store,
    input  logic             m_addr_err,
    output logic             w_valid,
    output logic [WIDTH-1:0] w_data,
    output logic [RN_W-1:0]  w_rn,
    output logic             w_wreg,
    output logic             exc_req,
    output logic [4:0]       exc_code,
    output logic [WIDTH-1:0] exc_epc,
    output logic [WIDTH-1:0] exc_badvaddr,
    input  logic             exc_ack,
    output logic [31:0]      retire_cnt
);

    typedef enum logic {IDLE, PEND} exc_state_t;

    exc_state_t state, state_n;
    logic       load;
    logic       fault;
    logic       capture;

    assign load  = ~flush & ~stall;
    assign fault = load & m_valid & m_addr_err;

    // Pipeline register: rst > flush (bubble) > stall (hold) > load
    always_ff @(posedge clk) begin
        if (rst) begin
            w_valid <= 1'b0;
            w_data  <= '0;
            w_rn    <= '0;
            w_wreg  <= 1'b0;
        end else if (flush) begin
            w_valid <= 1'b0;
            w_data  <= '0;
            w_rn    <= '0;
            w_wreg  <= 1'b0;
        end else if (!stall) begin
            w_valid <= m_valid & ~m_addr_err;
            w_data  <= m_m2reg ? m_ramout : m_alu;
            w_rn    <= m_rn;
            w_wreg  <= m_valid & m_wreg & ~m_addr_err & (m_rn != '0);
        end
    end

    // Retired-instruction counter, free-running wrap
    always_ff @(posedge clk) begin
        if (rst)
            retire_cnt <= '0;
        else if (load && m_valid && !m_addr_err)
            retire_cnt <= retire_cnt + 32'd1;
    end

    // Exception FSM state register
    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_n;
    end

    // Next state; a fault arriving with exc_ack replaces the acknowledged one
    always_comb begin
        state_n = state;
        capture = 1'b0;
        case (state)
            IDLE: begin
                if (fault) begin
                    state_n = PEND;
                    capture = 1'b1;
                end
            end
            PEND: begin
                if (exc_ack) begin
                    if (fault) begin
                        state_n = PEND;
                        capture = 1'b1;
                    end else begin
                        state_n = IDLE;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Exception request output
    always_comb begin
        exc_req = (state == PEND);
    end

    // Exception detail fields, latched only when a fault is accepted
    always_ff @(posedge clk) begin
        if (rst) begin
            exc_code     <= '0;
            exc_epc      <= '0;
            exc_badvaddr <= '0;
        end else if (capture) begin
            exc_code     <= m_store ? 5'(EXC_ADES) : 5'(EXC_ADEL);
            exc_epc      <= m_pc;
            exc_badvaddr <= m_alu;
        end
    end

endmodule

// File: tb/tb_pipe_mem_wb.sv
// Self-checking bench for pipe_mem_wb: directed scenarios then random traffic
// compared against a cycle-level behavioural model.
module tb_pipe_mem_wb;

    logic        clk = 1'b0;
    logic        rst, stall, flush, m_valid, m_wreg, m_m2reg, m_store, m_addr_err, exc_ack;
    logic [31:0] m_pc, m_alu, m_ramout;
    logic [4:0]  m_rn;
    logic        w_valid, w_wreg, exc_req;
    logic [31:0] w_data, exc_epc, exc_badvaddr, retire_cnt;
    logic [4:0]  w_rn, exc_code;

    int checks = 0;
    int errors = 0;

    // behavioural model state
    logic        e_valid, e_wreg, e_pend;
    logic [31:0] e_data, e_epc, e_bad, e_cnt;
    logic [4:0]  e_rn, e_code;

    pipe_mem_wb #(.WIDTH(32), .RN_W(5), .EXC_ADEL(4), .EXC_ADES(5)) dut (
        .clk(clk), .rst(rst), .stall(stall), .flush(flush),
        .m_valid(m_valid), .m_pc(m_pc), .m_alu(m_alu), .m_ramout(m_ramout),
        .m_rn(m_rn), .m_wreg(m_wreg), .m_m2reg(m_m2reg), .m_store(m_store),
        .m_addr_err(m_addr_err),
        .w_valid(w_valid), .w_data(w_data), .w_rn(w_rn), .w_wreg(w_wreg),
        .exc_req(exc_req), .exc_code(exc_code), .exc_epc(exc_epc),
        .exc_badvaddr(exc_badvaddr), .exc_ack(exc_ack), .retire_cnt(retire_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        e_valid = 0; e_wreg = 0; e_pend = 0; e_data = 0; e_epc = 0;
        e_bad = 0; e_cnt = 0; e_rn = 0; e_code = 0;
    endtask

    // Model of one rising edge, evaluated from the inputs held before it
    task automatic model_edge();
        logic faulting, take;
        if (rst) begin
            model_reset();
            return;
        end
        faulting = !flush && !stall && m_valid && m_addr_err;
        take     = faulting && (!e_pend || exc_ack);
        if (exc_ack) e_pend = 0;
        if (take) begin
            e_pend = 1;
            e_epc  = m_pc;
            e_bad  = m_alu;
            e_code = m_store ? 5'd5 : 5'd4;
        end
        if (flush) begin
            e_valid = 0; e_wreg = 0; e_rn = 0; e_data = 0;
        end else if (!stall) begin
            e_valid = m_valid && !m_addr_err;
            e_wreg  = m_valid && m_wreg && !m_addr_err && (m_rn != 0);
            e_rn    = m_rn;
            e_data  = m_m2reg ? m_ramout : m_alu;
            if (m_valid && !m_addr_err) e_cnt = e_cnt + 1;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".w_valid"},  32'(w_valid),    32'(e_valid));
        chk({tag, ".w_data"},   w_data,          e_data);
        chk({tag, ".w_rn"},     32'(w_rn),       32'(e_rn));
        chk({tag, ".w_wreg"},   32'(w_wreg),     32'(e_wreg));
        chk({tag, ".exc_req"},  32'(exc_req),    32'(e_pend));
        chk({tag, ".exc_code"}, 32'(exc_code),   32'(e_code));
        chk({tag, ".epc"},      exc_epc,         e_epc);
        chk({tag, ".badvaddr"}, exc_badvaddr,    e_bad);
        chk({tag, ".retire"},   retire_cnt,      e_cnt);
    endtask

    // Apply current inputs across one rising edge, then check #1 after it
    task automatic tick(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        rst = 0; stall = 0; flush = 0; m_valid = 0; m_wreg = 0; m_m2reg = 0;
        m_store = 0; m_addr_err = 0; exc_ack = 0; m_pc = 0; m_alu = 0;
        m_ramout = 0; m_rn = 0;
    endtask

    task automatic instr(input logic [31:0] pc, input logic [31:0] alu, input logic [31:0] ram,
                         input logic [4:0] rn, input logic wreg, input logic m2reg,
                         input logic store, input logic err);
        m_valid = 1; m_pc = pc; m_alu = alu; m_ramout = ram; m_rn = rn;
        m_wreg = wreg; m_m2reg = m2reg; m_store = store; m_addr_err = err;
    endtask

    initial begin
        logic [31:0] held_cnt;
        logic [31:0] held_data;
        model_reset();
        idle_inputs();
        rst = 1;
        @(negedge clk);
        tick("reset0");
        tick("reset1");
        rst = 0;

        // 1. load, no fault
        instr(32'h100, 32'h2000, 32'hFFFFFF80, 5'd8, 1, 1, 0, 0);
        tick("t1");
        chk("t1.data_const", w_data, 32'hFFFFFF80);
        chk("t1.cnt_const", retire_cnt, 32'd1);

        // 2. store fault, then acknowledge
        instr(32'h400, 32'h1002, 32'h0, 5'd9, 1, 0, 1, 1);
        tick("t2a");
        chk("t2.req_const", 32'(exc_req), 32'd1);
        chk("t2.code_const", 32'(exc_code), 32'd5);
        chk("t2.wreg_const", 32'(w_wreg), 32'd0);
        m_valid = 0; m_addr_err = 0; exc_ack = 1;
        tick("t2b");
        chk("t2.req_clear", 32'(exc_req), 32'd0);
        exc_ack = 0;

        // 3. second fault while pending is ignored; ack + new fault recaptures
        instr(32'h400, 32'h1002, 32'h0, 5'd3, 1, 0, 0, 1);
        tick("t3a");
        instr(32'h404, 32'h2003, 32'h0, 5'd3, 1, 0, 0, 1);
        tick("t3b");
        chk("t3.epc_hold", exc_epc, 32'h400);
        instr(32'h408, 32'h10, 32'h0, 5'd4, 1, 0, 0, 0);
        tick("t3c");
        instr(32'h404, 32'h2003, 32'h0, 5'd3, 1, 0, 1, 1);
        exc_ack = 1;
        tick("t3d");
        chk("t3.epc_new", exc_epc, 32'h404);
        chk("t3.req_stay", 32'(exc_req), 32'd1);
        exc_ack = 1; m_valid = 0; m_addr_err = 0;
        tick("t3e");
        exc_ack = 0;

        // 4. stall freezes state, stall+flush gives a bubble
        instr(32'h500, 32'h55, 32'h66, 5'd7, 1, 0, 0, 0);
        tick("t4pre");
        held_cnt = retire_cnt;
        held_data = w_data;
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            instr($urandom, $urandom, $urandom, 5'($urandom), 1, 1'($urandom), 0, 1'($urandom));
            tick("t4stall");
        end
        chk("t4.cnt_frozen", retire_cnt, held_cnt);
        chk("t4.data_frozen", w_data, held_data);
        flush = 1;
        instr(32'h600, 32'h77, 32'h88, 5'd6, 1, 0, 0, 0);
        tick("t4flush");
        chk("t4.bubble_valid", 32'(w_valid), 32'd0);
        stall = 0; flush = 0;

        // 5. reset while pending
        instr(32'h700, 32'h3, 32'h0, 5'd2, 1, 0, 0, 1);
        tick("t5a");
        rst = 1;
        tick("t5b");
        chk("t5.req_zero", 32'(exc_req), 32'd0);
        chk("t5.epc_zero", exc_epc, 32'd0);
        rst = 0;

        // 6. r0 destination, and counter wrap
        instr(32'h800, 32'h1234, 32'h0, 5'd0, 1, 0, 0, 0);
        tick("t6a");
        chk("t6.wreg_r0", 32'(w_wreg), 32'd0);
        chk("t6.valid_r0", 32'(w_valid), 32'd1);
        force dut.retire_cnt = 32'hFFFFFFFE;
        #1;
        release dut.retire_cnt;
        e_cnt = 32'hFFFFFFFE;
        tick("t6b");
        tick("t6c");
        chk("t6.wrap", retire_cnt, 32'd0);

        // random traffic against the model
        for (int n = 0; n < 400; n++) begin
            rst        = ($urandom_range(0, 49) == 0);
            stall      = ($urandom_range(0, 4) == 0);
            flush      = ($urandom_range(0, 7) == 0);
            exc_ack    = ($urandom_range(0, 3) == 0);
            m_valid    = 1'($urandom);
            m_addr_err = ($urandom_range(0, 5) == 0);
            m_pc       = $urandom;
            m_alu      = $urandom;
            m_ramout   = $urandom;
            m_rn       = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            m_wreg     = 1'($urandom);
            m_m2reg    = 1'($urandom);
            m_store    = 1'($urandom);
            tick("rand");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
